// File: rtl/sync_fifo_gen2_if.sv
// sync_fifo_gen2_if
//   Handshake and status bundle for sync_fifo_gen2.
//   master : producer/consumer side (drives din, wr_en, rd_en; observes data and status)
//   slave  : FIFO side (drives dout, flags, error pulses and data_count)
//   Signals: din, wr_en, rd_en, dout, full, empty, almost_full, almost_empty,
//            overflow, underflow, data_count[ADDR_W:0]
interface sync_fifo_gen2_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_W     = 4
);
  logic [DATA_WIDTH-1:0] din;
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] dout;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  overflow;
  logic                  underflow;
  logic [ADDR_W:0]       data_count;

  modport master (
    output din, wr_en, rd_en,
    input  dout, full, empty, almost_full, almost_empty, overflow, underflow, data_count
  );

  modport slave (
    input  din, wr_en, rd_en,
    output dout, full, empty, almost_full, almost_empty, overflow, underflow, data_count
  );
endinterface

// File: rtl/sync_fifo_gen2.sv
// sync_fifo_gen2
//   Single-clock FIFO with standard (FWFT=0) or first-word-fall-through (FWFT=1)
//   read mode, almost-full/almost-empty thresholds and registered overflow /
//   underflow pulses. Depth is 2**ADDR_W.
//   Ports:
//     clk         clock, rising edge
//     srstn       synchronous active-low reset
//     bus         sync_fifo_gen2_if.slave (data, handshake, flags, data_count)
//     peak_count  highest data_count since reset (only with SYNC_FIFO_WATERMARK_EN)
//   Build option: define SYNC_FIFO_WATERMARK_EN to add the peak_count watermark.
module sync_fifo_gen2 #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_W     = 4,
  parameter int FWFT       = 0,
  parameter int AFULL_TH   = 12,
  parameter int AEMPTY_TH  = 2
) (
  input  logic            clk,
  input  logic            srstn,
`ifdef SYNC_FIFO_WATERMARK_EN
  output logic [ADDR_W:0] peak_count,
`endif
  sync_fifo_gen2_if.slave bus
);

  localparam int              DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C  = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] AFULL_C  = AFULL_TH[ADDR_W:0];
  localparam logic [ADDR_W:0] AEMPTY_C = AEMPTY_TH[ADDR_W:0];

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]     wr_ptr;
  logic [ADDR_W-1:0]     rd_ptr;
  logic [ADDR_W:0]       count_q;
  logic [ADDR_W:0]       count_d;
  logic                  full;
  logic                  empty;
  logic                  rd_ok;
  logic                  wr_ok;
  logic                  ovf_q;
  logic                  udf_q;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  // A full FIFO still takes a write when a read frees a slot in the same cycle;
  // an empty FIFO never serves a read, even alongside a write.
  assign rd_ok = bus.rd_en & ~empty;
  assign wr_ok = bus.wr_en & (~full | rd_ok);

  always_comb begin
    count_d = count_q;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!srstn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_d;
      ovf_q   <= bus.wr_en & ~wr_ok;
      udf_q   <= bus.rd_en & ~rd_ok;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (srstn && wr_ok) mem[wr_ptr] <= bus.din;
  end

  generate
    if (FWFT == 0) begin : g_std
      logic [DATA_WIDTH-1:0] dout_q;
      always_ff @(posedge clk) begin
        if (!srstn)     dout_q <= '0;
        else if (rd_ok) dout_q <= mem[rd_ptr];
      end
      assign bus.dout = dout_q;
    end else begin : g_fwft
      // Head word shows combinationally; last_q remembers the most recently
      // popped word so dout holds while the FIFO sits empty.
      logic [DATA_WIDTH-1:0] last_q;
      always_ff @(posedge clk) begin
        if (!srstn)     last_q <= '0;
        else if (rd_ok) last_q <= mem[rd_ptr];
      end
      assign bus.dout = empty ? last_q : mem[rd_ptr];
    end
  endgenerate

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= AFULL_C);
  assign bus.almost_empty = (count_q <= AEMPTY_C);
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;
  assign bus.data_count   = count_q;

`ifdef SYNC_FIFO_WATERMARK_EN
  logic [ADDR_W:0] peak_q;
  always_ff @(posedge clk) begin
    if (!srstn)                peak_q <= '0;
    else if (count_d > peak_q) peak_q <= count_d;
  end
  assign peak_count = peak_q;
`endif

endmodule

// File: tb/tb_sync_fifo_gen2.sv
module tb_sync_fifo_gen2;
  logic clk = 1'b0;
  logic srstn;
  always #5 clk = ~clk;

  sync_fifo_gen2_if #(.DATA_WIDTH(8), .ADDR_W(4)) bus0 ();
  sync_fifo_gen2_if #(.DATA_WIDTH(8), .ADDR_W(4)) bus1 ();

`ifdef SYNC_FIFO_WATERMARK_EN
  logic [4:0] peak0, peak1;
`endif

  sync_fifo_gen2 #(.DATA_WIDTH(8), .ADDR_W(4), .FWFT(0), .AFULL_TH(12), .AEMPTY_TH(2)) dut0 (
    .clk(clk), .srstn(srstn),
`ifdef SYNC_FIFO_WATERMARK_EN
    .peak_count(peak0),
`endif
    .bus(bus0.slave));

  sync_fifo_gen2 #(.DATA_WIDTH(8), .ADDR_W(4), .FWFT(1), .AFULL_TH(12), .AEMPTY_TH(2)) dut1 (
    .clk(clk), .srstn(srstn),
`ifdef SYNC_FIFO_WATERMARK_EN
    .peak_count(peak1),
`endif
    .bus(bus1.slave));

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] q[$];
  logic [7:0] m_dout0;
  logic [7:0] m_last1;
  logic       m_ovf;
  logic       m_udf;
  int         m_peak;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    logic [7:0] exp_d1;
    n = q.size();
    exp_d1 = (n > 0) ? q[0] : m_last1;
    chk("count0", 32'(bus0.data_count), 32'(n));
    chk("count1", 32'(bus1.data_count), 32'(n));
    chk("full",   32'(bus0.full),         32'(n == 16));
    chk("empty",  32'(bus0.empty),        32'(n == 0));
    chk("afull",  32'(bus0.almost_full),  32'(n >= 12));
    chk("aempty", 32'(bus0.almost_empty), 32'(n <= 2));
    chk("empty1", 32'(bus1.empty),        32'(n == 0));
    chk("ovf",    32'(bus0.overflow),     32'(m_ovf));
    chk("udf",    32'(bus0.underflow),    32'(m_udf));
    chk("ovf1",   32'(bus1.overflow),     32'(m_ovf));
    chk("udf1",   32'(bus1.underflow),    32'(m_udf));
    chk("dout_std",  32'(bus0.dout), 32'(m_dout0));
    chk("dout_fwft", 32'(bus1.dout), 32'(exp_d1));
`ifdef SYNC_FIFO_WATERMARK_EN
    chk("peak0", 32'(peak0), 32'(m_peak));
    chk("peak1", 32'(peak1), 32'(m_peak));
`endif
  endtask

  // One clock: drive at negedge, model the edge, check 1 time unit after it.
  task automatic cycle(input logic rst_n, input logic wr, input logic rd, input logic [7:0] d);
    int  n;
    logic rd_ok, wr_ok;
    srstn = rst_n;
    bus0.wr_en = wr; bus0.rd_en = rd; bus0.din = d;
    bus1.wr_en = wr; bus1.rd_en = rd; bus1.din = d;
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      m_dout0 = 8'h00; m_last1 = 8'h00; m_ovf = 1'b0; m_udf = 1'b0; m_peak = 0;
    end else begin
      n = q.size();
      rd_ok = rd && (n > 0);
      wr_ok = wr && ((n < 16) || rd_ok);
      m_ovf = wr && !wr_ok;
      m_udf = rd && !rd_ok;
      if (rd_ok) begin
        m_dout0 = q[0];
        m_last1 = q[0];
        void'(q.pop_front());
      end
      if (wr_ok) q.push_back(d);
      if (q.size() > m_peak) m_peak = q.size();
    end
    #1;
    check_all();
    @(negedge clk);
  endtask

  initial begin
    srstn = 1'b0;
    bus0.wr_en = 1'b0; bus0.rd_en = 1'b0; bus0.din = 8'h00;
    bus1.wr_en = 1'b0; bus1.rd_en = 1'b0; bus1.din = 8'h00;
    q.delete();
    m_dout0 = 8'h00; m_last1 = 8'h00; m_ovf = 1'b0; m_udf = 1'b0; m_peak = 0;
    @(negedge clk);

    // 1. reset, fill with 0x00..0x0F
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b1, 1'b0, 8'(i));
    chk("fill_full", 32'(bus0.full), 32'd1);

    // 2. overflow on full, then drain in order
    cycle(1'b1, 1'b1, 1'b0, 8'hAA);
    chk("ovf_pulse", 32'(bus0.overflow), 32'd1);
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    chk("ovf_clear", 32'(bus0.overflow), 32'd0);
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 1'b1, 8'h00);
    chk("drain_last", 32'(bus0.dout), 32'h0F);

    // 3. simultaneous read/write on empty
    cycle(1'b1, 1'b1, 1'b1, 8'h5C);
    chk("udf_pulse", 32'(bus0.underflow), 32'd1);
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    chk("fwft_5c", 32'(bus1.dout), 32'h5C);

    // 4. full FIFO, streaming read+write across pointer wrap
    for (int i = 0; i < 15; i++) cycle(1'b1, 1'b1, 1'b0, 8'(8'h60 + i));
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b1, 1'b1, 8'(8'h80 + i));
    chk("stream_cnt", 32'(bus0.data_count), 32'd16);

    // 5. mid-burst reset, then a new word comes out first
    cycle(1'b1, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, 8'(8'h30 + i));
    cycle(1'b0, 1'b1, 1'b0, 8'hEE);
    chk("rst_dout", 32'(bus0.dout), 32'd0);
    cycle(1'b1, 1'b1, 1'b0, 8'hC3);
    cycle(1'b1, 1'b0, 1'b1, 8'h00);
    chk("post_rst_rd", 32'(bus0.dout), 32'hC3);

    // 6. watermark pattern: write 9, read 4, write 2
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 9; i++) cycle(1'b1, 1'b1, 1'b0, 8'(8'h10 + i));
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 2; i++) cycle(1'b1, 1'b1, 1'b0, 8'(8'h20 + i));
    chk("wm_count", 32'(bus0.data_count), 32'd7);
`ifdef SYNC_FIFO_WATERMARK_EN
    chk("wm_peak", 32'(peak0), 32'd9);
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    chk("wm_peak_rst", 32'(peak0), 32'd0);
`endif

    // randomized traffic with changing bias and rare resets
    for (int i = 0; i < 1500; i++) begin
      int bias;
      bias = (i / 250) % 3;
      cycle(($urandom_range(0, 199) != 0),
            ($urandom_range(0, 9) < (bias == 0 ? 8 : (bias == 1 ? 2 : 5))),
            ($urandom_range(0, 9) < (bias == 0 ? 2 : (bias == 1 ? 8 : 5))),
            8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
